// File: rtl/fetch_pc_gen_pkg.sv
// Shared fetch definitions: branch control-type encodings, PC generator FSM
// states and a helper that sizes slot-index fields.
package fetch_pc_gen_pkg;

   typedef enum logic [1:0] {
      CTRL_RETURN = 2'b00,
      CTRL_CALL   = 2'b01,
      CTRL_JUMP   = 2'b10,
      CTRL_COND   = 2'b11
   } ctrl_type_e;

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_MISS_REQ  = 2'd1,
      ST_MISS_WAIT = 2'd2
   } fetch_state_e;

   // A single-slot bundle still needs a one-bit index field.
   function automatic int slot_bits(input int fw);
      return (fw > 1) ? $clog2(fw) : 1;
   endfunction

endpackage

// File: rtl/fetch_pc_gen_slot_select.sv
// Finds the lowest predicted-taken slot of a fetch bundle and its target
// (RAS top for returns, BTB target otherwise).
module fetch_slot_select
   import fetch_pc_gen_pkg::*;
#(
   parameter int FETCH_WIDTH = 4,
   parameter int PC_WIDTH    = 32
)(
   input  logic [FETCH_WIDTH-1:0]          hit_i,
   input  logic [2*FETCH_WIDTH-1:0]        ctrl_type_i,
   input  logic [PC_WIDTH*FETCH_WIDTH-1:0] target_i,
   input  logic [FETCH_WIDTH-1:0]          prediction_i,
   input  logic [PC_WIDTH-1:0]             ras_addr_i,
   output logic                            taken_valid_o,
   output logic [slot_bits(FETCH_WIDTH)-1:0] taken_slot_o,
   output ctrl_type_e                      taken_type_o,
   output logic [PC_WIDTH-1:0]             taken_target_o
);

   localparam int SLOT_W = slot_bits(FETCH_WIDTH);

   logic [FETCH_WIDTH-1:0] slot_taken;

   always_comb begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         slot_taken[k] = hit_i[k] &&
            ((ctrl_type_e'(ctrl_type_i[2*k +: 2]) != CTRL_COND) || prediction_i[k]);
      end
   end

   // Scan from the top so the lowest taken slot is the last one written.
   always_comb begin
      taken_valid_o  = 1'b0;
      taken_slot_o   = '0;
      taken_type_o   = CTRL_RETURN;
      taken_target_o = '0;
      for (int k = FETCH_WIDTH - 1; k >= 0; k--) begin
         if (slot_taken[k]) begin
            taken_valid_o = 1'b1;
            taken_slot_o  = SLOT_W'(k);
            taken_type_o  = ctrl_type_e'(ctrl_type_i[2*k +: 2]);
            taken_target_o = (ctrl_type_e'(ctrl_type_i[2*k +: 2]) == CTRL_RETURN) ?
                             ras_addr_i : target_i[PC_WIDTH*k +: PC_WIDTH];
         end
      end
   end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: redirect priority, branch-predicted next PC, RAS
// push/pop requests and the instruction-cache miss request/wait FSM.
module fetch_pc_gen
   import fetch_pc_gen_pkg::*;
#(
   parameter int                  FETCH_WIDTH = 4,
   parameter int                  PC_WIDTH    = 32,
   parameter int                  INST_BYTES  = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
)(
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            recoverFlag_i,
   input  logic [PC_WIDTH-1:0]             recoverPC_i,
   input  logic                            exceptionFlag_i,
   input  logic [PC_WIDTH-1:0]             exceptionPC_i,
   input  logic                            flagRecoverEX_i,
   input  logic [PC_WIDTH-1:0]             targetAddrEX_i,
   input  logic                            flagRecoverID_i,
   input  logic                            flagRtrID_i,
   input  logic [PC_WIDTH-1:0]             targetAddrID_i,
   input  logic [PC_WIDTH-1:0]             addrRAS_CP_i,
   input  logic [FETCH_WIDTH-1:0]          btbHit_i,
   input  logic [2*FETCH_WIDTH-1:0]        btbCtrlType_i,
   input  logic [PC_WIDTH*FETCH_WIDTH-1:0] btbTarget_i,
   input  logic [FETCH_WIDTH-1:0]          prediction_i,
   input  logic [PC_WIDTH-1:0]             addrRAS_i,
   input  logic                            stall_i,
   input  logic                            icMiss_i,
   input  logic                            missAck_i,
   input  logic                            refillDone_i,
   output logic [PC_WIDTH-1:0]             pc_o,
   output logic                            pcValid_o,
   output logic                            fs1Ready_o,
   output logic                            takenValid_o,
   output logic [slot_bits(FETCH_WIDTH)-1:0] takenSlot_o,
   output logic                            pushRas_o,
   output logic [PC_WIDTH-1:0]             pushAddr_o,
   output logic                            popRas_o,
   output logic                            missReq_o,
   output logic [PC_WIDTH-1:0]             missAddr_o
);

   localparam int                  SLOT_W       = slot_bits(FETCH_WIDTH);
   localparam logic [PC_WIDTH-1:0] BUNDLE_BYTES = PC_WIDTH'(FETCH_WIDTH * INST_BYTES);
   localparam logic [PC_WIDTH-1:0] INST_STEP    = PC_WIDTH'(INST_BYTES);

   fetch_state_e          state_q, state_d;
   logic [PC_WIDTH-1:0]   pc_q, pc_d;
   logic [PC_WIDTH-1:0]   miss_addr_q, miss_addr_d;
   logic                  miss_req_q, miss_req_d;

   logic                  taken_valid;
   logic [SLOT_W-1:0]     taken_slot;
   ctrl_type_e            taken_type;
   logic [PC_WIDTH-1:0]   taken_target;

   logic                  hard_redirect;
   logic                  run_en;
   logic                  ras_en;

   fetch_slot_select #(
      .FETCH_WIDTH (FETCH_WIDTH),
      .PC_WIDTH    (PC_WIDTH)
   ) u_slot_select (
      .hit_i          (btbHit_i),
      .ctrl_type_i    (btbCtrlType_i),
      .target_i       (btbTarget_i),
      .prediction_i   (prediction_i),
      .ras_addr_i     (addrRAS_i),
      .taken_valid_o  (taken_valid),
      .taken_slot_o   (taken_slot),
      .taken_type_o   (taken_type),
      .taken_target_o (taken_target)
   );

   // Backend redirects override everything, including a pending miss.
   assign hard_redirect = recoverFlag_i || exceptionFlag_i || flagRecoverEX_i;
   assign run_en        = (state_q == ST_RUN) && !stall_i && !icMiss_i;
   assign ras_en        = run_en && !hard_redirect && !flagRecoverID_i && reset;

   always_comb begin
      pc_d = pc_q;
      if (recoverFlag_i) begin
         pc_d = recoverPC_i;
      end else if (exceptionFlag_i) begin
         pc_d = exceptionPC_i;
      end else if (flagRecoverEX_i) begin
         pc_d = targetAddrEX_i;
      end else if (run_en) begin
         if (flagRecoverID_i) begin
            pc_d = flagRtrID_i ? addrRAS_CP_i : targetAddrID_i;
         end else if (taken_valid) begin
            pc_d = taken_target;
         end else begin
            pc_d = pc_q + BUNDLE_BYTES;
         end
      end
   end

   // A redirect in MISS_WAIT only moves the PC; the refill still has to land.
   always_comb begin
      state_d     = state_q;
      miss_addr_d = miss_addr_q;
      miss_req_d  = miss_req_q;
      case (state_q)
         ST_RUN: begin
            if (icMiss_i && !hard_redirect) begin
               state_d     = ST_MISS_REQ;
               miss_addr_d = pc_q - (pc_q % BUNDLE_BYTES);
               miss_req_d  = 1'b1;
            end
         end
         ST_MISS_REQ: begin
            if (hard_redirect) begin
               state_d    = ST_RUN;
               miss_req_d = 1'b0;
            end else if (missAck_i) begin
               state_d    = ST_MISS_WAIT;
               miss_req_d = 1'b0;
            end
         end
         ST_MISS_WAIT: begin
            if (refillDone_i) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d    = ST_RUN;
            miss_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_RUN;
         pc_q        <= RESET_PC;
         miss_addr_q <= '0;
         miss_req_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         miss_addr_q <= miss_addr_d;
         miss_req_q  <= miss_req_d;
      end
   end

   assign pc_o         = pc_q;
   assign pcValid_o    = (state_q == ST_RUN) && !icMiss_i;
   assign fs1Ready_o   = pcValid_o;
   assign takenValid_o = taken_valid;
   assign takenSlot_o  = taken_slot;
   assign pushRas_o    = ras_en && taken_valid && (taken_type == CTRL_CALL);
   assign popRas_o     = ras_en && taken_valid && (taken_type == CTRL_RETURN);
   assign pushAddr_o   = pushRas_o ?
                         pc_q + (PC_WIDTH'(taken_slot) + PC_WIDTH'(1)) * INST_STEP : pc_q;
   // The request drops in the very cycle a redirect abandons it.
   assign missReq_o    = miss_req_q && !hard_redirect;
   assign missAddr_o   = miss_addr_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed, table-driven bench for fetch_pc_gen (FETCH_WIDTH=4, INST_BYTES=8).
module tb_fetch_pc_gen;

   logic          clk = 1'b0;
   logic          reset;
   logic          recover_flag, exception_flag, ex_flag, id_flag, id_rtr;
   logic [31:0]   recover_pc, exception_pc, ex_target, id_target, ras_cp;
   logic [3:0]    btb_hit, prediction;
   logic [7:0]    btb_ctrl_type;
   logic [127:0]  btb_target;
   logic [31:0]   ras_addr;
   logic          stall, ic_miss, miss_ack, refill_done;
   logic [31:0]   pc, push_addr, miss_addr;
   logic          pc_valid, fs1_ready, taken_valid, push_ras, pop_ras, miss_req;
   logic [1:0]    taken_slot;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic [31:0]  start_pc;
      logic [3:0]   hit;
      logic [7:0]   ctype;
      logic [127:0] tgt;
      logic [3:0]   pred;
      logic [31:0]  ras;
      logic         stall;
      logic         id_flag;
      logic         id_rtr;
      logic [31:0]  id_tgt;
      logic         ex_flag;
      logic [31:0]  ex_tgt;
      logic         exp_tv;
      logic [1:0]   exp_slot;
      logic         exp_push;
      logic [31:0]  exp_push_addr;
      logic         exp_pop;
      logic [31:0]  exp_pc;
   } vec_t;

   vec_t vecs[14];

   always #5 clk = ~clk;

   fetch_pc_gen #(
      .FETCH_WIDTH (4),
      .PC_WIDTH    (32),
      .INST_BYTES  (8),
      .RESET_PC    (32'h0)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .recoverFlag_i   (recover_flag),
      .recoverPC_i     (recover_pc),
      .exceptionFlag_i (exception_flag),
      .exceptionPC_i   (exception_pc),
      .flagRecoverEX_i (ex_flag),
      .targetAddrEX_i  (ex_target),
      .flagRecoverID_i (id_flag),
      .flagRtrID_i     (id_rtr),
      .targetAddrID_i  (id_target),
      .addrRAS_CP_i    (ras_cp),
      .btbHit_i        (btb_hit),
      .btbCtrlType_i   (btb_ctrl_type),
      .btbTarget_i     (btb_target),
      .prediction_i    (prediction),
      .addrRAS_i       (ras_addr),
      .stall_i         (stall),
      .icMiss_i        (ic_miss),
      .missAck_i       (miss_ack),
      .refillDone_i    (refill_done),
      .pc_o            (pc),
      .pcValid_o       (pc_valid),
      .fs1Ready_o      (fs1_ready),
      .takenValid_o    (taken_valid),
      .takenSlot_o     (taken_slot),
      .pushRas_o       (push_ras),
      .pushAddr_o      (push_addr),
      .popRas_o        (pop_ras),
      .missReq_o       (miss_req),
      .missAddr_o      (miss_addr)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic clearInputs();
      recover_flag = 1'b0; recover_pc = '0;
      exception_flag = 1'b0; exception_pc = '0;
      ex_flag = 1'b0; ex_target = '0;
      id_flag = 1'b0; id_rtr = 1'b0; id_target = '0;
      ras_cp = 32'hA40;
      btb_hit = '0; btb_ctrl_type = '0; btb_target = '0; prediction = '0;
      ras_addr = '0;
      stall = 1'b0; ic_miss = 1'b0; miss_ack = 1'b0; refill_done = 1'b0;
   endtask

   // Called one tick after a rising edge; returns one tick after the next.
   task automatic loadPc(input logic [31:0] new_pc);
      recover_flag = 1'b1;
      recover_pc   = new_pc;
      @(posedge clk); #1;
      recover_flag = 1'b0;
   endtask

   task automatic applyStimulus(input int idx, input vec_t v);
      loadPc(v.start_pc);
      btb_hit = v.hit; btb_ctrl_type = v.ctype; btb_target = v.tgt;
      prediction = v.pred; ras_addr = v.ras; stall = v.stall;
      id_flag = v.id_flag; id_rtr = v.id_rtr; id_target = v.id_tgt;
      ex_flag = v.ex_flag; ex_target = v.ex_tgt;
      #4;
      checkOutput($sformatf("v%0d takenValid", idx), 64'(taken_valid), 64'(v.exp_tv));
      if (v.exp_tv)
         checkOutput($sformatf("v%0d takenSlot", idx), 64'(taken_slot), 64'(v.exp_slot));
      checkOutput($sformatf("v%0d pushRas", idx), 64'(push_ras), 64'(v.exp_push));
      checkOutput($sformatf("v%0d pushAddr", idx), 64'(push_addr), 64'(v.exp_push_addr));
      checkOutput($sformatf("v%0d popRas", idx), 64'(pop_ras), 64'(v.exp_pop));
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d nextPc", idx), 64'(pc), 64'(v.exp_pc));
      clearInputs();
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // start_pc, hit, ctype, tgt, pred, ras, stall, id, rtr, id_tgt, ex, ex_tgt,
      // exp_tv, exp_slot, exp_push, exp_push_addr, exp_pop, exp_pc
      vecs[0]  = '{32'h100, 4'b0000, 8'h00, 128'h0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,
                   1'b0, 2'd0, 1'b0, 32'h100, 1'b0, 32'h120};
      vecs[1]  = '{32'h200, 4'b0110, 8'b00_10_01_00, 128'h00000000_00000999_00000400_00000000, 4'b0000,
                   32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 2'd1, 1'b1, 32'h210, 1'b0, 32'h400};
      vecs[2]  = '{32'h300, 4'b0101, 8'b00_00_00_11, 128'h00000000_00000000_00000000_00000777, 4'b0000,
                   32'h880, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 2'd2, 1'b0, 32'h300, 1'b1, 32'h880};
      vecs[3]  = '{32'h340, 4'b1000, 8'b11_00_00_00, 128'h00007000_00000000_00000000_00000000, 4'b1000,
                   32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 2'd3, 1'b0, 32'h340, 1'b0, 32'h7000};
      vecs[4]  = '{32'h400, 4'b0001, 8'b00_00_00_01, 128'h00000000_00000000_00000000_00001234, 4'b0000,
                   32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 32'h400, 1'b0, 32'h400};
      vecs[5]  = '{32'h500, 4'b0001, 8'b00_00_00_01, 128'h00000000_00000000_00000000_00000111, 4'b0000,
                   32'h0, 1'b0, 1'b1, 1'b0, 32'h900, 1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 32'h500, 1'b0, 32'h900};
      vecs[6]  = '{32'h600, 4'b0000, 8'h00, 128'h0, 4'b0000, 32'h0, 1'b0, 1'b1, 1'b1, 32'h123, 1'b0, 32'h0,
                   1'b0, 2'd0, 1'b0, 32'h600, 1'b0, 32'hA40};
      vecs[7]  = '{32'hFFFFFFF0, 4'b0000, 8'h00, 128'h0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,
                   1'b0, 2'd0, 1'b0, 32'hFFFFFFF0, 1'b0, 32'h10};
      vecs[8]  = '{32'h100, 4'b0000, 8'h00, 128'h0, 4'b0000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h500,
                   1'b0, 2'd0, 1'b0, 32'h100, 1'b0, 32'h500};
      vecs[9]  = '{32'h1000, 4'b1000, 8'b01_00_00_00, 128'h00002000_00000000_00000000_00000000, 4'b0000,
                   32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 2'd3, 1'b1, 32'h1020, 1'b0, 32'h2000};
      vecs[10] = '{32'h1100, 4'b0001, 8'b00_00_00_01, 128'h00000000_00000000_00000000_00003000, 4'b0000,
                   32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h600, 1'b1, 2'd0, 1'b0, 32'h1100, 1'b0, 32'h600};
      vecs[11] = '{32'h1200, 4'b0010, 8'h00, 128'h0, 4'b0000, 32'h4440, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,
                   1'b1, 2'd1, 1'b0, 32'h1200, 1'b0, 32'h1200};
      vecs[12] = '{32'h1300, 4'b0011, 8'b00_00_00_11, 128'h0, 4'b0000, 32'h4440, 1'b0, 1'b0, 1'b0, 32'h0,
                   1'b0, 32'h0, 1'b1, 2'd1, 1'b0, 32'h1300, 1'b1, 32'h4440};
      vecs[13] = '{32'h1400, 4'b0011, 8'b00_00_01_10, 128'h00000000_00000000_00009990_00005550, 4'b0000,
                   32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 2'd0, 1'b0, 32'h1400, 1'b0, 32'h5550};

      // Reset state, with a call hit present to show RAS pushes are held off.
      clearInputs();
      reset = 1'b0;
      btb_hit = 4'b0001; btb_ctrl_type = 8'b00_00_00_01;
      #1;
      checkOutput("reset pc", 64'(pc), 64'h0);
      checkOutput("reset missReq", 64'(miss_req), 64'h0);
      checkOutput("reset missAddr", 64'(miss_addr), 64'h0);
      checkOutput("reset pushRas", 64'(push_ras), 64'h0);
      checkOutput("reset pcValid", 64'(pc_valid), 64'h1);
      clearInputs();
      @(posedge clk); @(posedge clk); #1;
      checkOutput("reset held pc", 64'(pc), 64'h0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("release pc", 64'(pc), 64'h0);
      @(posedge clk); #1;
      checkOutput("first fetch advance", 64'(pc), 64'h20);

      // Sequential fetch from 0x100.
      loadPc(32'h100);
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("seq step %0d", i), 64'(pc), 64'(32'h100 + 32'(i) * 32'h20));
      end
      checkOutput("fs1Ready", 64'(fs1_ready), 64'h1);

      for (int i = 0; i < 14; i++) applyStimulus(i, vecs[i]);

      // Recover beats EX, exception beats EX, both while stalled.
      stall = 1'b1;
      recover_flag = 1'b1; recover_pc = 32'hC00; ex_flag = 1'b1; ex_target = 32'h500;
      @(posedge clk); #1;
      checkOutput("recover over EX", 64'(pc), 64'hC00);
      recover_flag = 1'b0;
      exception_flag = 1'b1; exception_pc = 32'hD00;
      @(posedge clk); #1;
      checkOutput("exception over EX", 64'(pc), 64'hD00);
      clearInputs();

      // Miss, delayed ack, redirect during MISS_WAIT, then refill.
      loadPc(32'h1234);
      ic_miss = 1'b1;
      #1;
      checkOutput("miss pcValid low", 64'(pc_valid), 64'h0);
      @(posedge clk); #1;
      ic_miss = 1'b0;
      checkOutput("missReq raised", 64'(miss_req), 64'h1);
      checkOutput("missAddr aligned", 64'(miss_addr), 64'h1220);
      checkOutput("miss pc held", 64'(pc), 64'h1234);
      refill_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         refill_done = 1'b0;
         checkOutput($sformatf("missReq held %0d", i), 64'(miss_req), 64'h1);
      end
      miss_ack = 1'b1;
      @(posedge clk); #1;
      miss_ack = 1'b0;
      checkOutput("after ack missReq", 64'(miss_req), 64'h0);
      checkOutput("after ack pcValid", 64'(pc_valid), 64'h0);
      ex_flag = 1'b1; ex_target = 32'h500; miss_ack = 1'b1;
      @(posedge clk); #1;
      ex_flag = 1'b0; miss_ack = 1'b0;
      checkOutput("wait redirect pc", 64'(pc), 64'h500);
      checkOutput("wait redirect pcValid", 64'(pc_valid), 64'h0);
      @(posedge clk); #1;
      checkOutput("still waiting", 64'(pc_valid), 64'h0);
      checkOutput("waiting pc", 64'(pc), 64'h500);
      refill_done = 1'b1;
      @(posedge clk); #1;
      refill_done = 1'b0;
      checkOutput("refill pcValid", 64'(pc_valid), 64'h1);
      checkOutput("refill pc", 64'(pc), 64'h500);
      @(posedge clk); #1;
      checkOutput("refetch advance", 64'(pc), 64'h520);

      // Redirect while the request is outstanding withdraws it at once.
      loadPc(32'h2000);
      ic_miss = 1'b1;
      @(posedge clk); #1;
      ic_miss = 1'b0;
      checkOutput("req2 missReq", 64'(miss_req), 64'h1);
      checkOutput("req2 missAddr", 64'(miss_addr), 64'h2000);
      ex_flag = 1'b1; ex_target = 32'h700; miss_ack = 1'b1;
      #1;
      checkOutput("req2 withdrawn", 64'(miss_req), 64'h0);
      @(posedge clk); #1;
      ex_flag = 1'b0; miss_ack = 1'b0;
      checkOutput("req2 redirect pc", 64'(pc), 64'h700);
      checkOutput("req2 back in RUN", 64'(pc_valid), 64'h1);
      @(posedge clk); #1;
      checkOutput("req2 advance", 64'(pc), 64'h720);

      // Reset asserted while a miss request is pending.
      loadPc(32'h3000);
      ic_miss = 1'b1;
      @(posedge clk); #1;
      ic_miss = 1'b0;
      checkOutput("req3 missReq", 64'(miss_req), 64'h1);
      reset = 1'b0;
      #1;
      checkOutput("mid-miss reset missReq", 64'(miss_req), 64'h0);
      checkOutput("mid-miss reset pc", 64'(pc), 64'h0);
      checkOutput("mid-miss reset missAddr", 64'(miss_addr), 64'h0);
      @(posedge clk); #1;
      checkOutput("reset hold missReq", 64'(miss_req), 64'h0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      checkOutput("post reset pc", 64'(pc), 64'h20);
      checkOutput("post reset missReq", 64'(miss_req), 64'h0);
      checkOutput("post reset pcValid", 64'(pc_valid), 64'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
